// File: rtl/cs_trgt_sync_pkg.sv
// rtl/cs_trgt_sync_pkg.sv - shared types, mode constants and index-width helper
package cs_trgt_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int MODE_PUT    = 0;
  localparam int MODE_GET    = 1;
  localparam int MODE_PUTGET = 2;

  // Index width that never collapses to zero bits for single-entry sets.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cs_edge_sync.sv
// rtl/cs_edge_sync.sv - 2-flop synchroniser plus rising-edge detect for one mission clock
module cs_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  // [0],[1] synchronise, [2] holds the previous synchronised level.
  logic [2:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], async_i};
    end
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/cs_trgt_sync_ctrl.sv
// rtl/cs_trgt_sync_ctrl.sv - target-side co-simulation exchange controller
module cs_trgt_sync_ctrl
  import cs_trgt_sync_pkg::*;
#(
  parameter int N_CLK    = 4,
  parameter int N_CH     = 3,
  parameter int DATA_W   = 8,
  parameter int MODE     = 2,
  parameter int WDOG_MAX = 10000,
  localparam int DW      = DATA_W + 1,
  localparam int CLK_W   = idx_w(N_CLK),
  localparam int CH_W    = idx_w(N_CH),
  localparam int WD_W    = $clog2(WDOG_MAX + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CLK-1:0]     clk_h_i,
  output logic [N_CLK-1:0]     freeze_clk_o,
  input  logic [DW-1:0]        ul_data_i,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [DW-1:0]        tx_data_o,
  output logic [CLK_W-1:0]     tx_clk_idx_o,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  input  logic [CH_W-1:0]      rx_ch_i,
  input  logic [DW-1:0]        rx_data_i,
  input  logic                 rx_last_i,
  output logic [N_CH*DW-1:0]   dl_data_o,
  output logic [N_CH-1:0]      dl_upd_o,
  output logic                 busy_o,
  output logic                 wdog_err_o,
  output logic                 proto_err_o
);

  logic [N_CLK-1:0] rise, pending_q, done_mask, pend_kept, pending_nxt;
  logic [DW-1:0]    snap_q [N_CLK];
  logic [DW-1:0]    dl_q   [N_CH];
  state_t           state_q;
  logic [CLK_W-1:0] cur_q, sel;
  logic [WD_W-1:0]  wdog_q;
  logic             done, tx_hs, rx_hs, ch_ok;

  for (genvar k = 0; k < N_CLK; k++) begin : g_sync
    cs_edge_sync u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (clk_h_i[k]),
      .rise_o  (rise[k])
    );
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_dl
    assign dl_data_o[c*DW +: DW] = dl_q[c];
  end

  // tx_valid_o / rx_ready_o are high for the whole of SEND / RECV, so the
  // handshakes reduce to state plus the partner's signal.
  always_comb begin
    tx_hs       = (state_q == SEND) && tx_ready_i;
    rx_hs       = (state_q == RECV) && rx_valid_i;
    done        = ((MODE == MODE_PUT) && tx_hs) || (rx_hs && rx_last_i);
    done_mask   = '0;
    done_mask[cur_q] = done;
    pend_kept   = pending_q & ~done_mask;
    pending_nxt = pend_kept | rise;
    ch_ok       = int'(rx_ch_i) < N_CH;
    sel         = '0;
    for (int k = N_CLK - 1; k >= 0; k--) begin
      if (pending_q[k]) sel = CLK_W'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      freeze_clk_o <= '0;
      cur_q        <= '0;
      wdog_q       <= '0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= '0;
      tx_clk_idx_o <= '0;
      rx_ready_o   <= 1'b0;
      busy_o       <= 1'b0;
      wdog_err_o   <= 1'b0;
      proto_err_o  <= 1'b0;
      dl_upd_o     <= '0;
      for (int k = 0; k < N_CLK; k++) snap_q[k] <= '0;
      for (int c = 0; c < N_CH; c++)  dl_q[c]   <= '0;
    end else begin
      dl_upd_o  <= '0;
      pending_q <= pending_nxt;
      if (state_q != ERR) freeze_clk_o <= pending_nxt;

      // A repeat edge on a still-pending clock is merged and flagged; the
      // snapshot is only taken for edges that open a new request.
      if (|(rise & pend_kept)) proto_err_o <= 1'b1;
      for (int k = 0; k < N_CLK; k++) begin
        if (rise[k] && !pend_kept[k]) snap_q[k] <= ul_data_i;
      end

      if (rx_hs) begin
        if (ch_ok) begin
          dl_q[rx_ch_i]     <= rx_data_i;
          dl_upd_o[rx_ch_i] <= 1'b1;
        end else begin
          proto_err_o <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            cur_q        <= sel;
            tx_clk_idx_o <= sel;
            busy_o       <= 1'b1;
            if (MODE == MODE_GET) begin
              state_q    <= RECV;
              rx_ready_o <= 1'b1;
            end else begin
              state_q    <= SEND;
              tx_valid_o <= 1'b1;
              tx_data_o  <= snap_q[sel];
            end
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            if (MODE == MODE_PUT) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q    <= RECV;
              rx_ready_o <= 1'b1;
            end
          end
        end
        RECV: begin
          if (rx_valid_i && rx_last_i) begin
            state_q    <= IDLE;
            rx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        ERR: ;
        default: state_q <= IDLE;
      endcase

      // Watchdog only runs while an exchange is waiting on the transport.
      if (state_q == SEND || state_q == RECV) begin
        if (tx_hs || rx_hs) begin
          wdog_q <= '0;
        end else if (wdog_q == WD_W'(WDOG_MAX - 1)) begin
          wdog_q     <= '0;
          wdog_err_o <= 1'b1;
          state_q    <= ERR;
          tx_valid_o <= 1'b0;
          rx_ready_o <= 1'b0;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
      end else begin
        wdog_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cs_trgt_sync_ctrl.sv
// tb/tb_cs_trgt_sync_ctrl.sv - directed and table-driven checks for cs_trgt_sync_ctrl
module tb_cs_trgt_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  clk_h;
  logic [8:0]  ul_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [1:0]  rx_ch;
  logic [8:0]  rx_data;
  logic        rx_last;

  logic [3:0]  freeze_a, freeze_b;
  logic        tx_valid_a, tx_valid_b;
  logic [8:0]  tx_data_a, tx_data_b;
  logic [1:0]  tx_idx_a, tx_idx_b;
  logic        rx_ready_a, rx_ready_b;
  logic [26:0] dl_data_a, dl_data_b;
  logic [2:0]  dl_upd_a, dl_upd_b;
  logic        busy_a, busy_b, wdog_a, wdog_b, proto_a, proto_b;

  int total = 0;
  int bad   = 0;
  logic [26:0] model_a, model_b;

  typedef struct {
    logic [1:0] ch;
    logic [8:0] data;
    logic       last;
    logic [2:0] exp_upd;
    logic       exp_proto;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  cs_trgt_sync_ctrl #(.N_CLK(4), .N_CH(3), .DATA_W(8), .MODE(2), .WDOG_MAX(16)) u_a (
    .clk_i(clk), .rst_i(rst_a), .clk_h_i(clk_h), .freeze_clk_o(freeze_a),
    .ul_data_i(ul_data), .tx_valid_o(tx_valid_a), .tx_ready_i(tx_ready),
    .tx_data_o(tx_data_a), .tx_clk_idx_o(tx_idx_a), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_a), .rx_ch_i(rx_ch), .rx_data_i(rx_data), .rx_last_i(rx_last),
    .dl_data_o(dl_data_a), .dl_upd_o(dl_upd_a), .busy_o(busy_a),
    .wdog_err_o(wdog_a), .proto_err_o(proto_a)
  );

  cs_trgt_sync_ctrl #(.N_CLK(4), .N_CH(3), .DATA_W(8), .MODE(1), .WDOG_MAX(16)) u_b (
    .clk_i(clk), .rst_i(rst_b), .clk_h_i(clk_h), .freeze_clk_o(freeze_b),
    .ul_data_i(ul_data), .tx_valid_o(tx_valid_b), .tx_ready_i(tx_ready),
    .tx_data_o(tx_data_b), .tx_clk_idx_o(tx_idx_b), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_b), .rx_ch_i(rx_ch), .rx_data_i(rx_data), .rx_last_i(rx_last),
    .dl_data_o(dl_data_b), .dl_upd_o(dl_upd_b), .busy_o(busy_b),
    .wdog_err_o(wdog_b), .proto_err_o(proto_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // sel: 0 = tx_valid_a, 1 = rx_ready_a, 2 = rx_ready_b
  task automatic wait_hi(input int sel, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      case (sel)
        0: seen = tx_valid_a;
        1: seen = rx_ready_a;
        default: seen = rx_ready_b;
      endcase
    end
    chk({nm, "_timeout"}, seen, 1'b1);
  endtask

  task automatic tx_hs();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic rx_beat(input logic [1:0] ch, input logic [8:0] d, input logic last);
    rx_valid = 1'b1; rx_ch = ch; rx_data = d; rx_last = last;
    tick();
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ch: 2'd0, data: 9'h011, last: 1'b0, exp_upd: 3'b001, exp_proto: 1'b0};
    vecs[1] = '{ch: 2'd2, data: 9'h1FF, last: 1'b0, exp_upd: 3'b100, exp_proto: 1'b0};
    vecs[2] = '{ch: 2'd3, data: 9'h0AA, last: 1'b0, exp_upd: 3'b000, exp_proto: 1'b1};
    vecs[3] = '{ch: 2'd1, data: 9'h155, last: 1'b1, exp_upd: 3'b010, exp_proto: 1'b1};

    rst_a = 1'b1; rst_b = 1'b1; clk_h = '0; ul_data = '0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_ch = '0; rx_data = '0; rx_last = 1'b0;
    model_a = '0; model_b = '0;
    @(negedge clk);
    tick(3);
    chk("rst_freeze", freeze_a, 4'b0);
    chk("rst_txv", tx_valid_a, 1'b0);
    chk("rst_txd", tx_data_a, 9'h0);
    chk("rst_rxr", rx_ready_a, 1'b0);
    chk("rst_dl", dl_data_a, 27'h0);
    chk("rst_flags", {busy_a, wdog_a, proto_a, dl_upd_a, tx_idx_a}, 8'h0);
    rst_a = 1'b0;
    tick();

    // Basic put-then-get exchange on clock 0 with a stalled transport.
    ul_data = 9'h1A5; clk_h[0] = 1'b1;
    tick(2);
    chk("t1_freeze_early", freeze_a, 4'b0000);
    tick();
    chk("t1_freeze_up", freeze_a, 4'b0001);
    clk_h[0] = 1'b0;
    tick();
    chk("t1_txv", tx_valid_a, 1'b1);
    chk("t1_txd", tx_data_a, 9'h1A5);
    chk("t1_idx", tx_idx_a, 2'd0);
    chk("t1_busy", busy_a, 1'b1);
    ul_data = 9'h0F0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1_stall%0d", i), {tx_valid_a, tx_data_a}, {1'b1, 9'h1A5});
    end
    tx_hs();
    chk("t1_recv", {tx_valid_a, rx_ready_a, tx_idx_a}, {1'b0, 1'b1, 2'd0});
    rx_beat(2'd1, 9'h142, 1'b1);
    model_a[9 +: 9] = 9'h142;
    chk("t1_upd", dl_upd_a, 3'b010);
    chk("t1_dl", dl_data_a, model_a);
    chk("t1_freeze_dn", freeze_a, 4'b0000);
    chk("t1_idle", {busy_a, rx_ready_a, proto_a}, 3'b000);
    tick();
    chk("t1_upd_pulse", dl_upd_a, 3'b000);

    // Simultaneous edges on clocks 2 and 1: lowest index first.
    ul_data = 9'h033; clk_h[2:1] = 2'b11;
    tick(3);
    chk("t2_freeze_both", freeze_a, 4'b0110);
    clk_h[2:1] = 2'b00;
    tick();
    chk("t2_first", {tx_valid_a, tx_idx_a}, {1'b1, 2'd1});
    tx_hs();
    chk("t2_recv1", {rx_ready_a, tx_idx_a}, {1'b1, 2'd1});
    rx_beat(2'd0, 9'h100, 1'b1);
    model_a[0 +: 9] = 9'h100;
    chk("t2_freeze_mid", freeze_a, 4'b0100);
    chk("t2_dl1", dl_data_a, model_a);
    tick();
    chk("t2_second", {tx_valid_a, tx_idx_a, tx_data_a}, {1'b1, 2'd2, 9'h033});
    tx_hs();
    rx_beat(2'd2, 9'h0C3, 1'b1);
    model_a[18 +: 9] = 9'h0C3;
    chk("t2_freeze_end", freeze_a, 4'b0000);
    chk("t2_dl2", dl_data_a, model_a);

    // Reset during SEND abandons the exchange.
    ul_data = 9'h0AB; clk_h[3] = 1'b1;
    wait_hi(0, "t5_send");
    clk_h[3] = 1'b0;
    rst_a = 1'b1;
    tick();
    model_a = '0;
    chk("t5_rst", {tx_valid_a, freeze_a, busy_a}, 6'b0);
    chk("t5_rst_dl", dl_data_a, model_a);
    rst_a = 1'b0;
    tick(4);
    chk("t5_stay_idle", busy_a, 1'b0);
    ul_data = 9'h0EE; clk_h[3] = 1'b1;
    wait_hi(0, "t5_resend");
    clk_h[3] = 1'b0;
    chk("t5_txd", {tx_data_a, tx_idx_a}, {9'h0EE, 2'd3});
    tx_hs();
    rx_beat(2'd2, 9'h1EE, 1'b1);
    model_a[18 +: 9] = 9'h1EE;
    chk("t5_done", {freeze_a, busy_a, proto_a}, 6'b0);
    chk("t5_dl", dl_data_a, model_a);

    // Repeat edge on a clock still pending is merged and flagged.
    ul_data = 9'h077; clk_h[0] = 1'b1;
    tick(3);
    clk_h[0] = 1'b0;
    tick();
    chk("t4_send", tx_valid_a, 1'b1);
    clk_h[0] = 1'b1;
    tick(3);
    chk("t4_proto", {proto_a, freeze_a, tx_data_a}, {1'b1, 4'b0001, 9'h077});
    clk_h[0] = 1'b0;
    tx_hs();
    rx_beat(2'd0, 9'h001, 1'b1);
    chk("t4_freeze_dn", freeze_a, 4'b0000);
    tick(2);
    chk("t4_merged", busy_a, 1'b0);

    // Get-only instance: table-driven download beats.
    rst_a = 1'b1;
    rst_b = 1'b0;
    tick();
    clk_h[1] = 1'b1;
    wait_hi(2, "tb_recv");
    clk_h[1] = 1'b0;
    chk("tb_idx", {tx_idx_b, tx_valid_b, freeze_b}, {2'd1, 1'b0, 4'b0010});
    for (int i = 0; i < 4; i++) begin
      rx_beat(vecs[i].ch, vecs[i].data, vecs[i].last);
      if (int'(vecs[i].ch) < 3) model_b[int'(vecs[i].ch)*9 +: 9] = vecs[i].data;
      chk($sformatf("vec%0d_upd", i), dl_upd_b, vecs[i].exp_upd);
      chk($sformatf("vec%0d_dl", i), dl_data_b, model_b);
      chk($sformatf("vec%0d_proto", i), proto_b, vecs[i].exp_proto);
      chk($sformatf("vec%0d_busy", i), busy_b, !vecs[i].last);
    end
    chk("tb_freeze_dn", freeze_b, 4'b0000);

    // Watchdog expiry in RECV.
    clk_h[0] = 1'b1;
    wait_hi(2, "wd_recv");
    clk_h[0] = 1'b0;
    tick(15);
    chk("wd_early", {wdog_b, busy_b, rx_ready_b}, 3'b011);
    tick();
    chk("wd_err", wdog_b, 1'b1);
    chk("wd_hold", {busy_b, rx_ready_b, tx_valid_b, freeze_b}, {3'b100, 4'b0001});
    tick(3);
    chk("wd_sticky", {wdog_b, busy_b, freeze_b}, {2'b11, 4'b0001});
    rst_b = 1'b1;
    tick();
    chk("wd_rst", {wdog_b, proto_b, busy_b, freeze_b, rx_ready_b, tx_valid_b, dl_upd_b}, 13'h0);
    chk("wd_rst_dl", dl_data_b, 27'h0);
    rst_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cs_trgt_sync_ctrl.md
Name: cs_trgt_sync_ctrl

Overview:
- Parametrised, synthesizable target-side co-simulation exchange controller.
- Watches up to N_CLK mission clocks. On each mission-clock rising edge it freezes that clock, sends the sampled upload vector to the initiator transport, and optionally waits for download beats. It then releases the clock.
- Sits between the target SUT wrapper and the transport adapter (TCP/DPI bridge).
- Replaces the single-channel, fixed-width, simulation-only flow with configurable channels, data width, mode and watchdog, plus explicit valid/ready handshakes.

Parameters:
- N_CLK, 4, number of mission clocks monitored/frozen (1..8)
- N_CH, 3, number of download channels (1..8)
- DATA_W, 8, payload width per channel (excluding write-enable bit)
- MODE, 2, 0 = put only, 1 = get only, 2 = put then get
- WDOG_MAX, 10000, clk_i cycles without a handshake before watchdog error (≥2)

Ports:
- clk_i  in  1  utility clock; all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- clk_h_i  in  N_CLK  mission clocks (asynchronous to clk_i)
- freeze_clk_o  out  N_CLK  per-clock freeze request; 1 = block mission clock
- ul_data_i  in  DATA_W+1  upload vector {valid, data} from the SUT
- tx_valid_o  out  1  upload beat valid
- tx_ready_i  in  1  transport accepts upload beat
- tx_data_o  out  DATA_W+1  upload beat payload
- tx_clk_idx_o  out  $clog2(N_CLK)>0?..:1  index of the mission clock being serviced
- rx_valid_i  in  1  download beat valid
- rx_ready_o  out  1  controller accepts download beat
- rx_ch_i  in  $clog2(N_CH)>0?..:1  target channel of the download beat
- rx_data_i  in  DATA_W+1  download payload {wen, data}
- rx_last_i  in  1  final beat of this exchange
- dl_data_o  out  N_CH*(DATA_W+1)  held per-channel {wen, data}; channel c at bits [c*(DATA_W+1) +: DATA_W+1]
- dl_upd_o  out  N_CH  1-cycle pulse when channel c is updated
- busy_o  out  1  exchange in progress (state ≠ IDLE)
- wdog_err_o  out  1  sticky watchdog error
- proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0. dl_data_o, pending, snapshot and watchdog cleared; FSM goes to IDLE. Reset mid-exchange abandons the exchange; tx_valid_o may drop without tx_ready_i.
- Edge detect, per clock k: 2-flop synchroniser, then rising-edge detect. If clk_h_i[k] rises before clk_i edge E0, then at E2 pending[k] ← 1, freeze_clk_o[k] ← 1, and ul_data_i is captured into snap[k].
- Another edge on k while pending[k] = 1: set proto_err_o; that edge is merged (not queued twice).
- FSM states are IDLE, SEND, RECV, ERR.
  - IDLE: if any pending bit is set, select the lowest index k, latch cur = k, and go to SEND (MODE 0/2) or RECV (MODE 1). Each transition takes 1 cycle.
  - SEND: tx_valid_o = 1, tx_data_o = snap[cur], tx_clk_idx_o = cur. Payload is held stable until tx_ready_i. On the handshake: MODE 0 → DONE action, MODE 2 → RECV.
  - RECV: rx_ready_o = 1 and tx_clk_idx_o = cur. On each rx_valid_i & rx_ready_o beat:
    - rx_ch_i < N_CH: dl channel ← rx_data_i and dl_upd_o[rx_ch_i] pulses the next cycle.
    - rx_ch_i ≥ N_CH: beat dropped, proto_err_o set.
    - rx_last_i = 1: DONE action.
  - DONE action, same edge as the final handshake: pending[cur] ← 0, freeze_clk_o[cur] ← 0, next state IDLE.
  - ERR: terminal until reset. rx_ready_o = 0, tx_valid_o = 0, and freezes stay as they are.
- Watchdog:
  - Counts clk_i cycles in SEND/RECV.
  - Clears on any handshake and on leaving SEND/RECV.
  - When it reaches WDOG_MAX: wdog_err_o ← 1, state → ERR.
- A pending edge on another clock that arrives while busy is serviced after the current exchange, by lowest index first. Simultaneous edges are handled the same way.
- A new edge on clock cur detected in the same cycle as its DONE sets pending[cur] again; set wins over clear.
- Width rules: tx_data_o and dl channels are exactly DATA_W+1 bits, with no extension.

Decomposition:
- Package cs_trgt_sync_pkg holds:
  - state enum (IDLE, SEND, RECV, ERR)
  - MODE constants (MODE_PUT = 0, MODE_GET = 1, MODE_PUTGET = 2)
  - index-width helper function.
- Sub-module cs_edge_sync: 2-flop synchroniser plus rising-edge detect for one clock. It is instantiated N_CLK times in a generate loop.

Test Plan:
- MODE 2, defaults: pulse clk_h_i[0] with ul_data_i = 9'h1A5 → freeze_clk_o[0] rises 3 cycles later. Then tx beat with tx_data_o = 9'h1A5 and tx_clk_idx_o = 0. Then rx beat ch 1, data 9'h142, last = 1 → dl channel 1 = 9'h142, dl_upd_o = 3'b010, freeze_clk_o[0] falls.
- Simultaneous clk_h_i[2] and clk_h_i[1] edges → clock 1 is serviced fully before clock 2. freeze_clk_o = 4'b0110, then 4'b0100, then 4'b0000.
- tx_ready_i held low for 5 cycles → tx_data_o remains stable. Change ul_data_i meanwhile → tx_data_o still holds the snapshot.
- MODE 1, rx_ch_i = 3 with N_CH = 3 → beat dropped, proto_err_o = 1, dl_data_o unchanged. A following legal last beat completes the exchange.
- WDOG_MAX = 16, no rx_valid_i in RECV → wdog_err_o = 1 at the 16th cycle, busy_o stays 1, and freeze stays asserted. rst_i then clears all outputs to 0.
- Assert rst_i in the middle of a SEND → tx_valid_o = 0 and freeze_clk_o = 0 the next cycle, FSM in IDLE. Clean exchange afterwards.
